// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer driving a registered full adder, one bit pair per LAT+1-cycle slot, LSB first.
// Latency: done pulses in the cycle after accept edge + WIDTH*(LAT+1) (24 cycles for 8/2).
// Backpressure: none; start is only sampled in IDLE, so requests while busy or scanning are dropped.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    input  logic             scan_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             add_a,
    output logic             add_b,
    output logic             add_c,
    output logic             add_cg_en,
    output logic             add_scan_en,
    input  logic             add_sum,
    input  logic             add_carry
);

    localparam int SW = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam int IW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [SW-1:0] SLOT_LAST = SW'(LAT);
    localparam logic [IW-1:0] BIT_LAST  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             add_a_q, add_a_d;
    logic             add_b_q, add_b_d;
    logic             add_c_q, add_c_d;
    logic             add_cg_en_q, add_cg_en_d;
    logic             add_scan_en_q, add_scan_en_d;
    logic [IW-1:0]    bit_idx_nxt;

    assign bit_idx_nxt = bit_idx_q + IW'(1);

    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        slot_d        = slot_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        acc_d         = acc_q;
        sum_d         = sum_q;
        carry_out_d   = carry_out_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        add_c_d       = add_c_q;
        add_cg_en_d   = add_cg_en_q;
        add_scan_en_d = add_scan_en_q;

        case (state_q)
            IDLE: begin
                if (scan_mode) begin
                    state_d       = SCAN;
                    add_cg_en_d   = 1'b1;
                    add_scan_en_d = 1'b1;
                    add_a_d       = 1'b0;
                    add_b_d       = 1'b0;
                    add_c_d       = 1'b0;
                end else if (start) begin
                    state_d     = RUN;
                    op_a_d      = op_a;
                    op_b_d      = op_b;
                    add_a_d     = op_a[0];
                    add_b_d     = op_b[0];
                    add_c_d     = carry_in;
                    add_cg_en_d = 1'b1;
                    busy_d      = 1'b1;
                    bit_idx_d   = '0;
                    slot_d      = '0;
                end
            end
            RUN: begin
                if (scan_mode) begin
                    // Abort: the partial result in acc_q is simply dropped.
                    state_d       = SCAN;
                    busy_d        = 1'b0;
                    add_cg_en_d   = 1'b1;
                    add_scan_en_d = 1'b1;
                    add_a_d       = 1'b0;
                    add_b_d       = 1'b0;
                    add_c_d       = 1'b0;
                end else if (slot_q == SLOT_LAST) begin
                    acc_d[bit_idx_q] = add_sum;
                    if (bit_idx_q != BIT_LAST) begin
                        bit_idx_d = bit_idx_nxt;
                        slot_d    = '0;
                        add_a_d   = op_a_q[bit_idx_nxt];
                        add_b_d   = op_b_q[bit_idx_nxt];
                        add_c_d   = add_carry;
                    end else begin
                        state_d     = IDLE;
                        sum_d       = acc_d;
                        carry_out_d = add_carry;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        add_cg_en_d = 1'b0;
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            SCAN: begin
                if (!scan_mode) begin
                    state_d       = IDLE;
                    add_cg_en_d   = 1'b0;
                    add_scan_en_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            slot_q        <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            acc_q         <= '0;
            sum_q         <= '0;
            carry_out_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            add_a_q       <= 1'b0;
            add_b_q       <= 1'b0;
            add_c_q       <= 1'b0;
            add_cg_en_q   <= 1'b0;
            add_scan_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            slot_q        <= slot_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            acc_q         <= acc_d;
            sum_q         <= sum_d;
            carry_out_q   <= carry_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            add_c_q       <= add_c_d;
            add_cg_en_q   <= add_cg_en_d;
            add_scan_en_q <= add_scan_en_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sum         = sum_q;
    assign carry_out   = carry_out_q;
    assign add_a       = add_a_q;
    assign add_b       = add_b_q;
    assign add_c       = add_c_q;
    assign add_cg_en   = add_cg_en_q;
    assign add_scan_en = add_scan_en_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl with a behavioural two-stage registered full adder and an op scoreboard.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             Clock = 1'b0;
    logic             Reset_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
    logic             scan_mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             add_a;
    logic             add_b;
    logic             add_c;
    logic             add_cg_en;
    logic             add_scan_en;
    logic             add_sum;
    logic             add_carry;

    serial_add_ctrl #(.WIDTH(WIDTH), .LAT(2)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .carry_in   (carry_in),
        .scan_mode  (scan_mode),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .carry_out  (carry_out),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_c      (add_c),
        .add_cg_en  (add_cg_en),
        .add_scan_en(add_scan_en),
        .add_sum    (add_sum),
        .add_carry  (add_carry)
    );

    always #5 Clock = ~Clock;

    // Gated adder: input stage then output stage, both clocked only while cg_en is high.
    bit ar, br, cr, s_r, co_r;
    always @(posedge Clock) begin
        if (add_cg_en) begin
            ar   <= add_a;
            br   <= add_b;
            cr   <= add_c;
            s_r  <= ar ^ br ^ cr;
            co_r <= (ar & br) | (cr & (ar ^ br));
        end
    end
    assign add_sum   = s_r;
    assign add_carry = co_r;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] s;
        logic             co;
    } op_t;

    op_t sb_q[$];
    op_t cur;
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    int  acc_cyc = 0;
    int  last_done = 0;
    int  prev_done = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    function automatic logic carry_into(input op_t e, input int i);
        logic [31:0] m;
        logic [31:0] t;
        m = (32'd1 << i) - 32'd1;
        t = ({24'd0, e.a} & m) + ({24'd0, e.b} & m) + {31'd0, e.cin};
        return t[i];
    endfunction

    always @(posedge Clock) cyc++;

    // Per-cycle monitor: slot contents, gating, and scoreboard pop on done.
    always @(negedge Clock) begin
        if (Reset_n) begin
            if (busy && !prev_busy) begin
                if (sb_q.size() == 0) chk("accept_without_op", 32'd1, 32'd0);
                else cur = sb_q[0];
                acc_cyc = cyc;
            end
            if (busy) begin
                int n;
                int bi;
                n  = cyc - acc_cyc;
                bi = n / 3;
                if (bi < WIDTH) begin
                    chk("add_a", {31'd0, add_a}, {31'd0, cur.a[bi]});
                    chk("add_b", {31'd0, add_b}, {31'd0, cur.b[bi]});
                    chk("add_c", {31'd0, add_c}, {31'd0, carry_into(cur, bi)});
                end else begin
                    chk("busy_overrun", 32'd1, 32'd0);
                end
                chk("cg_en_run", {31'd0, add_cg_en}, 32'd1);
                chk("scan_en_run", {31'd0, add_scan_en}, 32'd0);
            end else if (!add_scan_en) begin
                chk("cg_en_idle", {31'd0, add_cg_en}, 32'd0);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    op_t e;
                    e = sb_q.pop_front();
                    chk("sum", {24'd0, sum}, {24'd0, e.s});
                    chk("carry_out", {31'd0, carry_out}, {31'd0, e.co});
                    chk("latency", cyc - acc_cyc, 32'd24);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
                prev_done = last_done;
                last_done = cyc;
            end
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        op_t e;
        logic [WIDTH:0] t;
        t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.a = a; e.b = b; e.cin = cin; e.s = t[WIDTH-1:0]; e.co = t[WIDTH];
        sb_q.push_back(e);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 10; i++) begin
            if (busy) return;
            tick();
        end
        chk("busy_timeout", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (done) return;
            tick();
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        push_op(a, b, cin);
        op_a = a; op_b = b; carry_in = cin; start = 1'b1;
        tick();
        wait_busy();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {19'd0, busy, done, sum, carry_out, add_a, add_b, add_c, add_cg_en, add_scan_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; scan_mode = 1'b0;
        tick(); tick();
        check_all_zero("reset_outputs");
        Reset_n = 1'b1;
        tick(); tick();
        check_all_zero("idle_after_reset");

        // Basic add with a stray start pulse mid-operation.
        launch(8'h5A, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        op_a = 8'hFF; op_b = 8'hFF; carry_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("sum_held", {24'd0, sum}, 32'h96);

        launch(8'hFF, 8'h01, 1'b0);
        wait_done();
        tick();
        launch(8'hFF, 8'hFF, 1'b1);
        wait_done();
        tick();

        // Back-to-back with start held high across both operations.
        push_op(8'h01, 8'h02, 1'b0);
        push_op(8'h10, 8'h20, 1'b0);
        op_a = 8'h01; op_b = 8'h02; carry_in = 1'b0; start = 1'b1;
        tick();
        wait_busy();
        op_a = 8'h10; op_b = 8'h20;
        wait_done();
        tick();
        chk("b2b_reaccept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done();
        chk("b2b_spacing", last_done - prev_done, 32'd25);
        tick();

        // Scan abort at cycle 10 of an add, with 0x96/0 as the prior result.
        launch(8'h5A, 8'h3C, 1'b0);
        wait_done();
        tick();
        launch(8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        scan_mode = 1'b1;
        tick();
        void'(sb_q.pop_front());
        chk("scan_busy", {31'd0, busy}, 32'd0);
        chk("scan_scan_en", {31'd0, add_scan_en}, 32'd1);
        chk("scan_cg_en", {31'd0, add_cg_en}, 32'd1);
        chk("scan_done", {31'd0, done}, 32'd0);
        chk("scan_sum_kept", {23'd0, carry_out, sum}, 32'h096);
        chk("scan_abc", {29'd0, add_a, add_b, add_c}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        scan_mode = 1'b0;
        tick();
        chk("unscan_scan_en", {31'd0, add_scan_en}, 32'd0);
        chk("unscan_cg_en", {31'd0, add_cg_en}, 32'd0);
        launch(8'h33, 8'h44, 1'b1);
        wait_done();
        tick();

        // Asynchronous reset between edges in the middle of an add.
        launch(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        #2;
        Reset_n = 1'b0;
        #1;
        check_all_zero("async_reset_mid_op");
        void'(sb_q.pop_front());
        tick(); tick();
        Reset_n = 1'b1;
        tick();
        launch(8'h80, 8'h80, 1'b0);
        wait_done();
        tick();
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
